// File: rtl/y_signature_misr.sv
// ============================================================================
// Module   : y_signature_misr
// Brief    : Folds the 501-bit result bus into a 32-bit MISR signature over a
//            programmed number of valid samples, handed off on valid/ready.
//            Optional change counter enabled by defining SIG_CHANGE_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module y_signature_misr #(
  parameter int               Y_W   = 501,
  parameter int               SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY  = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED  = 32'hFFFFFFFF,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_cyc,
  input  logic [Y_W-1:0]   y_in,
  input  logic             y_valid,
  output logic             busy,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic             sig_valid,
  input  logic             sig_ready,
`ifdef SIG_CHANGE_CNT_EN
  output logic [CNT_W-1:0] chg_cnt,
`endif
  output logic [SIG_W-1:0] sig_out
);

  localparam int C_NCHUNK = (Y_W + SIG_W - 1) / SIG_W;
  localparam int C_PAD_W  = C_NCHUNK * SIG_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SIG_W-1:0]   sig_q, sig_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   tgt_q, tgt_d;

  logic [C_PAD_W-1:0] w_padded;
  logic [SIG_W-1:0]   w_fold;
  logic [SIG_W-1:0]   w_sig_step;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_load;

  always_comb begin
    w_padded = '0;
    w_padded[Y_W-1:0] = y_in;
    w_fold = '0;
    for (int k = 0; k < C_NCHUNK; k++) begin
      w_fold = w_fold ^ w_padded[k*SIG_W +: SIG_W];
    end
    w_sig_step = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ w_fold;
    w_cnt_inc  = cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    w_load  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) w_load = 1'b1;
      end
      S_RUN: begin
        if (y_valid) begin
          sig_d = w_sig_step;
          cnt_d = w_cnt_inc;
          if (w_cnt_inc == tgt_q) state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Accepting the signature and starting in the same cycle skips IDLE.
        if (sig_ready) begin
          if (start) w_load = 1'b1;
          else       state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (w_load) begin
      state_d = S_RUN;
      sig_d   = SEED;
      cnt_d   = '0;
      tgt_d   = (num_cyc == '0) ? CNT_W'(1) : num_cyc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sig_q   <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign sig_valid = (state_q == S_DONE);
  assign cyc_cnt   = cnt_q;
  assign sig_out   = sig_q;

`ifdef SIG_CHANGE_CNT_EN
  logic [Y_W-1:0]   prev_q, prev_d;
  logic [CNT_W-1:0] chg_q, chg_d;

  always_comb begin
    prev_d = prev_q;
    chg_d  = chg_q;
    if (w_load) begin
      chg_d = '0;
    end else if (state_q == S_RUN && y_valid) begin
      prev_d = y_in;
      // cnt_q == 0 marks the first sample of the window, which has no predecessor.
      if (cnt_q != '0 && y_in != prev_q) chg_d = chg_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      chg_q  <= '0;
    end else begin
      prev_q <= prev_d;
      chg_q  <= chg_d;
    end
  end

  assign chg_cnt = chg_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_y_signature_misr.sv
// ============================================================================
// Module   : tb_y_signature_misr
// Brief    : Self-checking bench for y_signature_misr against a behavioural
//            signature model (default seed and zero-seed instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_y_signature_misr;

  localparam int          Y_W   = 501;
  localparam int          CNT_W = 16;
  localparam logic [31:0] POLY  = 32'h04C11DB7;
  localparam logic [31:0] SEED  = 32'hFFFFFFFF;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_cyc;
  logic [Y_W-1:0]   y_in;
  logic             y_valid;
  logic             sig_ready;
  logic             busy, busy1;
  logic [CNT_W-1:0] cyc_cnt, cyc_cnt1;
  logic             sig_valid, sig_valid1;
  logic [31:0]      sig_out, sig_out1;
`ifdef SIG_CHANGE_CNT_EN
  logic [CNT_W-1:0] chg_cnt, chg_cnt1;
`endif

  int total = 0;
  int bad   = 0;
  logic [Y_W-1:0] ya, yb, yfix;

  always #5 clk = ~clk;

  y_signature_misr dut (
    .clk(clk), .rst(rst), .start(start), .num_cyc(num_cyc), .y_in(y_in),
    .y_valid(y_valid), .busy(busy), .cyc_cnt(cyc_cnt), .sig_valid(sig_valid),
    .sig_ready(sig_ready),
`ifdef SIG_CHANGE_CNT_EN
    .chg_cnt(chg_cnt),
`endif
    .sig_out(sig_out)
  );

  y_signature_misr #(.SEED(32'h0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .num_cyc(num_cyc), .y_in(y_in),
    .y_valid(y_valid), .busy(busy1), .cyc_cnt(cyc_cnt1), .sig_valid(sig_valid1),
    .sig_ready(sig_ready),
`ifdef SIG_CHANGE_CNT_EN
    .chg_cnt(chg_cnt1),
`endif
    .sig_out(sig_out1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [Y_W-1:0] rand_y();
    logic [511:0] t;
    for (int k = 0; k < 16; k++) t[32*k +: 32] = $urandom;
    return t[Y_W-1:0];
  endfunction

  // Signature of a sample list: every bit i lands in signature bit (i mod 32).
  function automatic logic [31:0] model(input logic [Y_W-1:0] q[$], input logic [31:0] seed);
    logic [31:0] s, f;
    s = seed;
    foreach (q[n]) begin
      f = '0;
      for (int i = 0; i < Y_W; i++) f[i % 32] = f[i % 32] ^ q[n][i];
      s = (s << 1) ^ (s[31] ? POLY : 32'h0) ^ f;
    end
    return s;
  endfunction

  function automatic int changes(input logic [Y_W-1:0] q[$]);
    int c = 0;
    for (int i = 1; i < q.size(); i++) if (q[i] != q[i-1]) c++;
    return c;
  endfunction

  // mode: 0 always valid, 1 random gaps, 2 alternating, 3 A,A,B,B..., 4 fixed yfix
  task automatic window(input int n, input int mode, input bit do_start, output logic [31:0] exp_sig);
    logic [Y_W-1:0] q[$];
    logic [Y_W-1:0] y;
    int expn, cyc, idx;
    bit v;
    expn = (n == 0) ? 1 : n;
    if (do_start) begin
      start = 1'b1; num_cyc = CNT_W'(n);
      step();
      start = 1'b0;
    end
    check("win_busy", {63'd0, busy}, 64'd1);
    cyc = 0; idx = 0;
    while (sig_valid !== 1'b1 && cyc < 500) begin
      case (mode)
        1:       v = ($urandom_range(0, 1) == 1);
        2:       v = (cyc % 2 == 0);
        default: v = 1'b1;
      endcase
      case (mode)
        3:       y = (idx < 2) ? ya : yb;
        4:       y = yfix;
        default: y = rand_y();
      endcase
      y_valid = v; y_in = y;
      if (v) begin q.push_back(y); idx++; end
      step();
      cyc++;
    end
    y_valid = 1'b0;
    exp_sig = model(q, SEED);
    check("win_done", {63'd0, sig_valid}, 64'd1);
    if (mode == 2) check("win_cycles", 64'(cyc), 64'(2*expn-1));
    check("win_busy_off", {63'd0, busy}, 64'd0);
    check("win_cyc_cnt", {48'd0, cyc_cnt}, 64'(expn));
    check("win_sig", {32'd0, sig_out}, {32'd0, exp_sig});
    check("win_sig_seed0", {32'd0, sig_out1}, {32'd0, model(q, 32'h0)});
`ifdef SIG_CHANGE_CNT_EN
    check("win_chg_cnt", {48'd0, chg_cnt}, 64'(changes(q)));
`endif
  endtask

  task automatic accept();
    sig_ready = 1'b1;
    step();
    sig_ready = 1'b0;
    check("acc_valid_off", {63'd0, sig_valid}, 64'd0);
    check("acc_busy_off", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [31:0] es;
    logic [Y_W-1:0] q[$];
    rst = 1'b1; start = 1'b0; num_cyc = '0; y_in = '0; y_valid = 1'b0; sig_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_valid", {63'd0, sig_valid}, 64'd0);
    check("rst_sig", {32'd0, sig_out}, 64'd0);
    check("rst_cnt", {48'd0, cyc_cnt}, 64'd0);

    // Single zero sample from the default seed.
    yfix = '0;
    window(1, 4, 1'b1, es);
    check("t1_const", {32'd0, sig_out}, 64'hFB3EE249);
    accept();

    // Zero seed: bit 0 and the top bit (padding position).
    yfix = '0; yfix[0] = 1'b1;
    window(1, 4, 1'b1, es);
    check("t2_bit0", {32'd0, sig_out1}, 64'h00000001);
    accept();
    yfix = '0; yfix[500] = 1'b1;
    window(1, 4, 1'b1, es);
    check("t2_bit500", {32'd0, sig_out1}, 64'h00100000);
    accept();

    // Gapped samples 1,0,1,0,1.
    window(3, 2, 1'b1, es);
    accept();

    // DONE hold with sig_ready low, start ignored without ready, then restart.
    window(5, 1, 1'b1, es);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t4_hold_valid", {63'd0, sig_valid}, 64'd1);
      check("t4_hold_sig", {32'd0, sig_out}, {32'd0, es});
    end
    start = 1'b1; num_cyc = 16'd7;
    step();
    check("t4_nostart_valid", {63'd0, sig_valid}, 64'd1);
    check("t4_nostart_sig", {32'd0, sig_out}, {32'd0, es});
    sig_ready = 1'b1; num_cyc = 16'd2;
    step();
    start = 1'b0; sig_ready = 1'b0;
    check("t4_restart_busy", {63'd0, busy}, 64'd1);
    check("t4_restart_valid", {63'd0, sig_valid}, 64'd0);
    check("t4_restart_cnt", {48'd0, cyc_cnt}, 64'd0);
    check("t4_restart_seed", {32'd0, sig_out}, {32'd0, SEED});
    window(2, 0, 1'b0, es);
    accept();

    // Start during RUN is ignored.
    start = 1'b1; num_cyc = 16'd3;
    step();
    start = 1'b0;
    q = {};
    y_valid = 1'b1; y_in = rand_y(); q.push_back(y_in);
    step();
    start = 1'b1; num_cyc = 16'd9; y_in = rand_y(); q.push_back(y_in);
    step();
    start = 1'b0;
    check("t5_ign_cnt", {48'd0, cyc_cnt}, 64'd2);
    check("t5_ign_busy", {63'd0, busy}, 64'd1);
    y_in = rand_y(); q.push_back(y_in);
    step();
    y_valid = 1'b0;
    check("t5_ign_done", {63'd0, sig_valid}, 64'd1);
    check("t5_ign_cnt3", {48'd0, cyc_cnt}, 64'd3);
    check("t5_ign_sig", {32'd0, sig_out}, {32'd0, model(q, SEED)});
    accept();

    // Reset mid-window.
    start = 1'b1; num_cyc = 16'd5;
    step();
    start = 1'b0;
    y_valid = 1'b1; y_in = rand_y();
    step(); step();
    y_valid = 1'b0;
    check("t5_pre_rst_cnt", {48'd0, cyc_cnt}, 64'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_rst_busy", {63'd0, busy}, 64'd0);
    check("t5_rst_valid", {63'd0, sig_valid}, 64'd0);
    check("t5_rst_sig", {32'd0, sig_out}, 64'd0);
    check("t5_rst_cnt", {48'd0, cyc_cnt}, 64'd0);
    step();
    check("t5_rst_nosig", {63'd0, sig_valid}, 64'd0);

    // Change-count pattern and num_cyc=0.
    ya = rand_y(); yb = ~ya;
    window(4, 3, 1'b1, es);
    accept();
    window(0, 0, 1'b1, es);
    check("t6_zero_cnt", {48'd0, cyc_cnt}, 64'd1);
    accept();

    // Random windows with random gaps.
    for (int r = 0; r < 6; r++) begin
      window(int'($urandom_range(1, 9)), 1, 1'b1, es);
      accept();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
